// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory-stage load/store unit: op codes, funct3 codes,
// request/response payloads and FSM states.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_type;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        mem_op_type  op;
        logic [2:0]  funct3;
        logic [31:0] address;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
    } lsu_req_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        error;
    } lsu_rsp_type;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } lsu_state_type;

    // Loads accept signed/unsigned byte and half plus word; stores only B/H/W.
    function automatic logic funct3_legal(input mem_op_type op, input logic [2:0] funct3);
        logic legal;
        legal = 1'b1;
        if (op == OP_LOAD) begin
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end else if (op == OP_STORE) begin
            legal = (funct3 <= F3_W);
        end
        return legal;
    endfunction

endpackage

// File: rtl/load_store_unit_data_ram.sv
// Word-organised data RAM: synchronous 1-cycle read, per-byte write enables.
module load_store_unit_data_ram #(
    parameter int unsigned WORDS  = 256,
    parameter int unsigned ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read returns the pre-write contents when read and write hit the same cycle.
    always_comb begin
        rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: executes RV32I loads/stores against the data RAM and passes
// ALU results through; loads take one extra cycle and stall upstream.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned WORDS  = 256,
    parameter int unsigned ADDR_W = $clog2(WORDS)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    input  logic [4:0]  req_rd,
    input  logic        req_reg_write,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_reg_write,
    output logic        rsp_error
);

    localparam int unsigned BYTES = WORDS * 4;

    lsu_req_type   req;
    lsu_state_type state_q, state_d;
    lsu_rsp_type   rsp_q, rsp_d;
    logic [2:0]    ld_funct3_q, ld_funct3_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic [4:0]    ld_rd_q, ld_rd_d;

    logic              accept;
    logic              mem_op;
    logic              align_err;
    logic              req_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    assign req = '{op: mem_op_type'(req_op), funct3: req_funct3, address: req_address,
                   store_data: req_store_data, rd: req_rd, reg_write: req_reg_write};

    assign req_ready = (state_q == ST_IDLE) && reset_n;
    assign accept    = req_valid && req_ready;
    assign ram_addr  = req.address[ADDR_W+1:2];

    // Fault detection on the incoming request: alignment, range, funct3.
    always_comb begin
        mem_op = (req.op == OP_LOAD) || (req.op == OP_STORE);
        case (req.funct3[1:0])
            2'b01:   align_err = req.address[0];
            2'b10:   align_err = |req.address[1:0];
            default: align_err = 1'b0;
        endcase
        req_err = mem_op && (align_err || (req.address >= 32'(BYTES))
                             || !funct3_legal(req.op, req.funct3));
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        ram_we    = 4'b0000;
        ram_wdata = req.store_data;
        if (accept && (req.op == OP_STORE) && !req_err) begin
            case (req.funct3)
                F3_B: begin
                    ram_we    = 4'b0001 << req.address[1:0];
                    ram_wdata = {4{req.store_data[7:0]}};
                end
                F3_H: begin
                    ram_we    = req.address[1] ? 4'b1100 : 4'b0011;
                    ram_wdata = {2{req.store_data[15:0]}};
                end
                default: ram_we = 4'b1111;
            endcase
        end
    end

    load_store_unit_data_ram #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        rsp_d       = '0;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        ld_rd_d     = ld_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_d.valid = 1'b1;
                        rsp_d.data  = req.address;
                        rsp_d.rd    = req.rd;
                        rsp_d.error = 1'b1;
                    end else if (req.op == OP_LOAD) begin
                        state_d     = ST_LOAD_WAIT;
                        ld_funct3_d = req.funct3;
                        ld_off_d    = req.address[1:0];
                        ld_rd_d     = req.rd;
                    end else if (req.op == OP_STORE) begin
                        rsp_d.valid = 1'b1;
                        rsp_d.rd    = req.rd;
                    end else begin
                        rsp_d.valid     = 1'b1;
                        rsp_d.data      = req.address;
                        rsp_d.rd        = req.rd;
                        rsp_d.reg_write = req.reg_write;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                state_d         = ST_IDLE;
                rsp_d.valid     = 1'b1;
                rsp_d.data      = format_load(ram_rdata, ld_funct3_q, ld_off_q);
                rsp_d.rd        = ld_rd_q;
                rsp_d.reg_write = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rsp_q       <= '0;
            ld_funct3_q <= 3'b000;
            ld_off_q    <= 2'b00;
            ld_rd_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            rsp_q       <= rsp_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            ld_rd_q     <= ld_rd_d;
        end
    end

    assign rsp_valid     = rsp_q.valid;
    assign rsp_data      = rsp_q.data;
    assign rsp_rd        = rsp_q.rd;
    assign rsp_reg_write = rsp_q.reg_write;
    assign rsp_error     = rsp_q.error;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a byte-array memory model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned WORDS = 256;
    localparam int unsigned BYTES = WORDS * 4;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic [4:0]  req_rd;
    logic        req_reg_write;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_reg_write;
    logic        rsp_error;

    load_store_unit #(.WORDS(WORDS)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_funct3     (req_funct3),
        .req_address    (req_address),
        .req_store_data (req_store_data),
        .req_rd         (req_rd),
        .req_reg_write  (req_reg_write),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_rd         (rsp_rd),
        .rsp_reg_write  (rsp_reg_write),
        .rsp_error      (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] ed;
        logic        ee;
        logic        ew;
        int          lat;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [7:0] mem_b [BYTES];
    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-addressed memory, results derived from size/sign rules.
    task automatic model(inout vec_t v);
        int          size;
        logic        legal;
        logic [31:0] val;
        size  = (v.f3[1:0] == 2'd0) ? 1 : ((v.f3[1:0] == 2'd1) ? 2 : 4);
        v.ed  = v.addr;
        v.ee  = 1'b0;
        v.ew  = v.rw;
        v.lat = 1;
        if (v.op == 2'd1) legal = (v.f3 == 0 || v.f3 == 1 || v.f3 == 2 || v.f3 == 4 || v.f3 == 5);
        else              legal = (v.f3 <= 2);
        if (v.op == 2'd1 || v.op == 2'd2) begin
            v.ew = 1'b0;
            v.ee = !legal || (v.addr >= BYTES) || ((v.addr % size) != 0);
            if (!v.ee && v.op == 2'd2) begin
                for (int k = 0; k < size; k++) mem_b[v.addr + k] = v.sd[8*k +: 8];
                v.ed = 32'd0;
            end else if (!v.ee) begin
                val = 32'd0;
                for (int k = 0; k < size; k++) val = val | (32'(mem_b[v.addr + k]) << (8 * k));
                if (!v.f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
                v.ed  = val;
                v.ew  = 1'b1;
                v.lat = 2;
            end
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd, input logic rw);
        req_valid      = 1'b1;
        req_op         = op;
        req_funct3     = f3;
        req_address    = addr;
        req_store_data = sd;
        req_rd         = rd;
        req_reg_write  = rw;
    endtask

    // One isolated transaction: accept, measure latency, compare response.
    task automatic run(input string tag, input vec_t v);
        int   g;
        int   lat;
        logic rdy_after;
        g = 0;
        drive(v.op, v.f3, v.addr, v.sd, v.rd, v.rw);
        while (!req_ready && g < 10) begin
            step();
            g++;
        end
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        rdy_after = req_ready;
        lat = 1;
        while (!rsp_valid && lat < 5) begin
            step();
            lat++;
        end
        if (!rsp_valid) lat = 99;
        chk({tag, "/latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "/stall"}, 32'(rdy_after), (v.lat == 2) ? 32'd0 : 32'd1);
        chk({tag, "/data"}, rsp_data, v.ed);
        chk({tag, "/error"}, 32'(rsp_error), 32'(v.ee));
        chk({tag, "/reg_write"}, 32'(rsp_reg_write), 32'(v.ew));
        if (v.op == 2'd0 || (v.op == 2'd1 && !v.ee)) chk({tag, "/rd"}, 32'(rsp_rd), 32'(v.rd));
        step();
        chk({tag, "/pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        // op: 0 NONE, 1 LOAD, 2 STORE; expected {data, error, reg_write, latency}
        vecs[0]  = '{2'd2, F3_W,  32'h10,  32'hDEADBEEF, 5'd1,  1'b1, 32'h0,        1'b0, 1'b0, 1};
        vecs[1]  = '{2'd1, F3_W,  32'h10,  32'h0,        5'd2,  1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 2};
        vecs[2]  = '{2'd2, F3_W,  32'h20,  32'h80F17F01, 5'd3,  1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[3]  = '{2'd1, F3_B,  32'h20,  32'h0,        5'd4,  1'b1, 32'h00000001, 1'b0, 1'b1, 2};
        vecs[4]  = '{2'd1, F3_B,  32'h23,  32'h0,        5'd5,  1'b1, 32'hFFFFFF80, 1'b0, 1'b1, 2};
        vecs[5]  = '{2'd1, F3_BU, 32'h23,  32'h0,        5'd6,  1'b1, 32'h00000080, 1'b0, 1'b1, 2};
        vecs[6]  = '{2'd1, F3_H,  32'h22,  32'h0,        5'd7,  1'b1, 32'hFFFF80F1, 1'b0, 1'b1, 2};
        vecs[7]  = '{2'd1, F3_HU, 32'h22,  32'h0,        5'd8,  1'b1, 32'h000080F1, 1'b0, 1'b1, 2};
        vecs[8]  = '{2'd2, F3_W,  32'h30,  32'h0,        5'd9,  1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[9]  = '{2'd2, F3_B,  32'h31,  32'h123456AA, 5'd10, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[10] = '{2'd2, F3_H,  32'h32,  32'hABCD1234, 5'd10, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[11] = '{2'd1, F3_W,  32'h30,  32'h0,        5'd11, 1'b1, 32'h1234AA00, 1'b0, 1'b1, 2};
        vecs[12] = '{2'd2, F3_W,  32'h40,  32'hCAFEF00D, 5'd12, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[13] = '{2'd1, F3_W,  32'h41,  32'h0,        5'd13, 1'b1, 32'h41,       1'b1, 1'b0, 1};
        vecs[14] = '{2'd1, F3_W,  32'h40,  32'h0,        5'd14, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 2};
        vecs[15] = '{2'd2, F3_W,  32'h400, 32'h1,        5'd15, 1'b0, 32'h400,      1'b1, 1'b0, 1};
        vecs[16] = '{2'd1, 3'b011, 32'h10, 32'h0,        5'd16, 1'b1, 32'h10,       1'b1, 1'b0, 1};
        vecs[17] = '{2'd0, F3_B,  32'h55,  32'h0,        5'd7,  1'b1, 32'h55,       1'b0, 1'b1, 1};
        vecs[18] = '{2'd0, F3_W,  32'h12345678, 32'h0,   5'd0,  1'b0, 32'h12345678, 1'b0, 1'b0, 1};
        vecs[19] = '{2'd2, F3_H,  32'h33,  32'hFFFF,     5'd17, 1'b0, 32'h33,       1'b1, 1'b0, 1};
        vecs[20] = '{2'd2, 3'b011, 32'h10, 32'h0,        5'd18, 1'b0, 32'h10,       1'b1, 1'b0, 1};
        vecs[21] = '{2'd2, F3_W,  32'h3FC, 32'h11223344, 5'd19, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[22] = '{2'd1, F3_BU, 32'h3FF, 32'h0,        5'd20, 1'b0, 32'h00000011, 1'b0, 1'b1, 2};
        vecs[23] = '{2'd1, F3_H,  32'h3FE, 32'h0,        5'd21, 1'b0, 32'h00001122, 1'b0, 1'b1, 2};
        vecs[24] = '{2'd1, F3_B,  32'hFFFFFFFC, 32'h0,   5'd22, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1};
        vecs[25] = '{2'd1, F3_W,  32'h10,  32'h0,        5'd31, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 2};

        reset_n = 1'b0;
        drive(2'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        req_valid = 1'b0;

        // Reset: outputs quiet and not ready while held
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
            chk("reset/req_ready", 32'(req_ready), 32'd0);
        end
        chk("reset/rsp_data", rsp_data, 32'd0);
        chk("reset/rsp_rd", 32'(rsp_rd), 32'd0);
        chk("reset/rsp_flags", 32'({rsp_reg_write, rsp_error}), 32'd0);
        reset_n = 1'b1;
        step();
        chk("release/req_ready", 32'(req_ready), 32'd1);
        chk("release/rsp_valid", 32'(rsp_valid), 32'd0);

        // Directed vectors
        for (int i = 0; i < 26; i++) begin
            v = vecs[i];
            model(v);
            run($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back: store then load of same word, then a request held through the stall
        v = '{2'd2, F3_W, 32'h50, 32'h5A5A1234, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1};
        model(v);
        drive(2'd2, F3_W, 32'h50, 32'h5A5A1234, 5'd1, 1'b0);
        step();
        chk("b2b/store_valid", 32'(rsp_valid), 32'd1);
        chk("b2b/store_ready", 32'(req_ready), 32'd1);
        drive(2'd1, F3_W, 32'h50, 32'h0, 5'd9, 1'b0);
        step();
        chk("b2b/wait_valid", 32'(rsp_valid), 32'd0);
        chk("b2b/wait_ready", 32'(req_ready), 32'd0);
        drive(2'd0, F3_W, 32'h77, 32'h0, 5'd3, 1'b1);
        step();
        chk("b2b/load_valid", 32'(rsp_valid), 32'd1);
        chk("b2b/load_data", rsp_data, 32'h5A5A1234);
        chk("b2b/load_rd", 32'(rsp_rd), 32'd9);
        chk("b2b/ready_again", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b/none_valid", 32'(rsp_valid), 32'd1);
        chk("b2b/none_data", rsp_data, 32'h77);
        chk("b2b/none_rd", 32'(rsp_rd), 32'd3);
        step();
        chk("b2b/idle", 32'(rsp_valid), 32'd0);

        // Reset while a load is pending: no response may appear
        drive(2'd1, F3_W, 32'h10, 32'h0, 5'd4, 1'b0);
        step();
        req_valid = 1'b0;
        chk("abort/stall", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        step();
        chk("abort/valid0", 32'(rsp_valid), 32'd0);
        step();
        chk("abort/valid1", 32'(rsp_valid), 32'd0);
        chk("abort/ready_low", 32'(req_ready), 32'd0);
        reset_n = 1'b1;
        step();
        chk("abort/valid2", 32'(rsp_valid), 32'd0);
        chk("abort/ready", 32'(req_ready), 32'd1);

        // Fill the whole RAM so random loads see defined data
        for (int w = 0; w < int'(WORDS); w++) begin
            v = '{2'd2, F3_W, 32'(w * 4), $urandom, 5'($urandom_range(0, 31)), 1'b0,
                  32'h0, 1'b0, 1'b0, 1};
            model(v);
            run("fill", v);
        end

        // Random mixed traffic
        for (int n = 0; n < 300; n++) begin
            v.op   = 2'($urandom_range(0, 2));
            v.f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) v.addr = 32'(BYTES + $urandom_range(0, 4095));
            else                           v.addr = 32'($urandom_range(0, BYTES - 1));
            case ($urandom_range(0, 2))
                0:       v.addr = v.addr & ~32'd3;
                1:       v.addr = v.addr & ~32'd1;
                default: v.addr = v.addr;
            endcase
            v.sd = $urandom;
            v.rd = 5'($urandom_range(0, 31));
            v.rw = 1'($urandom_range(0, 1));
            model(v);
            run("rand", v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
